// File: rtl/interleaver_pkg.sv
// Shared limits and FSM encoding for the N-channel trigger interleaver.
package interleaver_pkg;

    localparam int NCH_MIN      = 2;
    localparam int NCH_MAX      = 8;
    localparam int SYNC_MIN     = 2;
    localparam int SYNC_MAX     = 4;
    localparam int SYNC_DEFAULT = 2;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

endpackage

// File: rtl/sync_bit.sv
// Single-bit multi-flop synchroniser, clearable by the synchronous reset.
module sync_bit
    import interleaver_pkg::*;
#(
    parameter int STAGES = SYNC_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    // Kept as discrete flops so the chain is never packed into an SRL.
    (* shreg_extract = "no", async_reg = "true" *) logic [STAGES-1:0] sync_p;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_p <= '0;
        end else begin
            sync_p <= {sync_p[STAGES-2:0], d};
        end
    end

    assign q = sync_p[STAGES-1];

endmodule

// File: rtl/interleaver_n.sv
// Trigger-driven channel selector: fixed lowest-channel or round-robin over a mask.
module interleaver_n
    import interleaver_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    trigger,
    input  logic                    interleave_b,
    input  logic                    ff_en,
    input  logic [NCH-1:0]          ch_mask,
    output logic [NCH-1:0]          output_en,
    output logic [$clog2(NCH)-1:0]  cur_ch,
    output logic                    wrap
);

    localparam int CW = $clog2(NCH);

    logic [NCH+1:0]   async_raw;
    logic [NCH+1:0]   async_s;
    logic [NCH-1:0]   mask_s;
    logic             interleave_s;
    logic             ff_en_s;
    logic [0:0]       state;

    logic [2*NCH-1:0] mask_dbl;
    logic [NCH-1:0]   rot_mask;
    logic [CW-1:0]    rr_ch;
    logic             rr_wrap;
    logic [CW-1:0]    lo_ch;
    logic             lo_found;

    assign async_raw = {ff_en, interleave_b, ch_mask};

    for (genvar i = 0; i < NCH + 2; i++) begin : g_sync
        sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (async_raw[i]),
            .q     (async_s[i])
        );
    end

    assign mask_s       = async_s[NCH-1:0];
    assign interleave_s = async_s[NCH];
    assign ff_en_s      = async_s[NCH+1];

    // Bit j of rot_mask is channel cur_ch+1+j (mod NCH), so the first hit is the next channel.
    assign mask_dbl = {mask_s, mask_s};
    assign rot_mask = NCH'(mask_dbl >> (int'(cur_ch) + 1));

    always_comb begin
        logic found;
        int   idx;
        found   = 1'b0;
        idx     = 0;
        rr_ch   = '0;
        rr_wrap = 1'b0;
        for (int j = 0; j < NCH; j++) begin
            if (!found && rot_mask[j]) begin
                found   = 1'b1;
                idx     = int'(cur_ch) + 1 + j;
                rr_wrap = (idx >= NCH);
                rr_ch   = CW'((idx >= NCH) ? idx - NCH : idx);
            end
        end
    end

    always_comb begin
        lo_found = 1'b0;
        lo_ch    = '0;
        for (int j = 0; j < NCH; j++) begin
            if (!lo_found && mask_s[j]) begin
                lo_found = 1'b1;
                lo_ch    = CW'(j);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            output_en <= '0;
            cur_ch    <= '0;
            wrap      <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (trigger) begin
                if (!ff_en_s || !lo_found) begin
                    state     <= ST_IDLE;
                    output_en <= '0;
                    cur_ch    <= '0;
                end else if (interleave_s && state == ST_ACTIVE) begin
                    state     <= ST_ACTIVE;
                    cur_ch    <= rr_ch;
                    output_en <= NCH'(1) << rr_ch;
                    wrap      <= rr_wrap;
                end else begin
                    state     <= ST_ACTIVE;
                    cur_ch    <= lo_ch;
                    output_en <= NCH'(1) << lo_ch;
                end
            end
        end
    end

endmodule

// File: tb/tb_interleaver_n.sv
// Scoreboard bench for interleaver_n (NCH=4, SYNC_STAGES=2) with a behavioural reference model.
module tb_interleaver_n;

    localparam int NCH = 4;
    localparam int SS  = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           trigger;
    logic           interleave_b;
    logic           ff_en;
    logic [NCH-1:0] ch_mask;
    logic [NCH-1:0] output_en;
    logic [1:0]     cur_ch;
    logic           wrap;

    interleaver_n #(.NCH(NCH), .SYNC_STAGES(SS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .trigger      (trigger),
        .interleave_b (interleave_b),
        .ff_en        (ff_en),
        .ch_mask      (ch_mask),
        .output_en    (output_en),
        .cur_ch       (cur_ch),
        .wrap         (wrap)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        logic [NCH-1:0] oe;
        logic [1:0]     ch;
        logic           wr;
    } exp_t;

    exp_t sb[$];

    // Reference model state and its own copy of the synchroniser delay line.
    logic           m_act = 1'b0;
    logic [1:0]     m_ch  = '0;
    logic [NCH-1:0] m_oe  = '0;
    logic [SS-1:0]  m_ie  = '0;
    logic [SS-1:0]  m_fe  = '0;
    logic [NCH-1:0] m_mk [SS];

    task automatic cycle(input logic trig, input string tag);
        exp_t           e;
        logic           ie_s;
        logic           fe_s;
        logic [NCH-1:0] mk_s;
        int             nxt;
        logic           wr;
        trigger = trig;
        ie_s    = m_ie[SS-1];
        fe_s    = m_fe[SS-1];
        mk_s    = m_mk[SS-1];
        wr      = 1'b0;
        if (!rst_n) begin
            m_act = 1'b0;
            m_ch  = '0;
            m_oe  = '0;
            m_ie  = '0;
            m_fe  = '0;
            for (int i = 0; i < SS; i++) m_mk[i] = '0;
        end else begin
            if (trig) begin
                nxt = -1;
                if (fe_s && mk_s != '0) begin
                    if (ie_s && m_act) begin
                        for (int k = m_ch + 1; k < NCH; k++)
                            if (nxt < 0 && mk_s[k]) nxt = k;
                        if (nxt < 0) wr = 1'b1;
                    end
                    if (nxt < 0)
                        for (int k = 0; k < NCH; k++)
                            if (nxt < 0 && mk_s[k]) nxt = k;
                end
                if (nxt < 0) begin
                    m_act = 1'b0;
                    m_ch  = '0;
                    m_oe  = '0;
                end else begin
                    m_act = 1'b1;
                    m_ch  = 2'(nxt);
                    m_oe  = NCH'(1) << nxt;
                end
            end
            for (int i = SS - 1; i > 0; i--) m_mk[i] = m_mk[i-1];
            m_mk[0] = ch_mask;
            m_ie    = {m_ie[SS-2:0], interleave_b};
            m_fe    = {m_fe[SS-2:0], ff_en};
        end
        sb.push_back('{m_oe, m_ch, wr});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({tag, ".oe"},   32'(output_en), 32'(e.oe));
        check({tag, ".ch"},   32'(cur_ch),    32'(e.ch));
        check({tag, ".wrap"}, 32'(wrap),      32'(e.wr));
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) cycle(1'b0, tag);
    endtask

    initial begin
        logic [NCH-1:0] seq31 [5];
        logic [NCH-1:0] seq32 [3];
        seq31[0] = 4'b0001; seq31[1] = 4'b0010; seq31[2] = 4'b0100;
        seq31[3] = 4'b1000; seq31[4] = 4'b0001;
        seq32[0] = 4'b0010; seq32[1] = 4'b1000; seq32[2] = 4'b0010;
        for (int i = 0; i < SS; i++) m_mk[i] = '0;

        rst_n = 1'b0; trigger = 1'b0; interleave_b = 1'b0; ff_en = 1'b0; ch_mask = '0;
        cycle(1'b0, "rst");
        cycle(1'b1, "rst_trig");
        check("rst.oe_const", 32'(output_en), 32'd0);
        rst_n = 1'b1;

        // Round-robin over a full mask.
        ff_en = 1'b1; interleave_b = 1'b1; ch_mask = 4'b1111;
        idle(3, "settle31");
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, "rr_full");
            check("rr_full.const", 32'(output_en), 32'(seq31[i]));
        end
        check("rr_full.wrap5", 32'(wrap), 32'd1);
        idle(2, "hold");
        check("hold.oe_const", 32'(output_en), 32'b0001);

        ch_mask = 4'b1010;
        idle(3, "settle32");
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, "rr_sparse");
            check("rr_sparse.const", 32'(output_en), 32'(seq32[i]));
        end
        check("rr_sparse.wrap3", 32'(wrap), 32'd1);

        interleave_b = 1'b0; ch_mask = 4'b0110;
        idle(3, "settle33");
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, "fixed");
            check("fixed.const", 32'(output_en), 32'b0010);
            check("fixed.nowrap", 32'(wrap), 32'd0);
        end

        // Single-channel mask: wraps onto itself.
        interleave_b = 1'b1; ch_mask = 4'b0100;
        idle(3, "settle19");
        for (int i = 0; i < 3; i++) cycle(1'b1, "single");
        check("single.wrap", 32'(wrap), 32'd1);

        ff_en = 1'b0;
        idle(3, "ffoff");
        cycle(1'b1, "ffoff_trig");
        check("ffoff.oe_const", 32'(output_en), 32'd0);
        check("ffoff.ch_const", 32'(cur_ch), 32'd0);

        ff_en = 1'b1; ch_mask = 4'b0000;
        idle(3, "settle20");
        cycle(1'b1, "zero_mask");

        ch_mask = 4'b1111;
        idle(3, "settle35");
        cycle(1'b1, "m35a");
        cycle(1'b1, "m35b");
        ch_mask = 4'b1001;
        idle(3, "settle35b");
        cycle(1'b1, "m35c");
        check("m35c.const", 32'(output_en), 32'b1000);
        cycle(1'b1, "m35d");
        check("m35d.const", 32'(output_en), 32'b0001);
        check("m35d.wrap", 32'(wrap), 32'd1);

        // Held trigger and a mode change seen only after the synchroniser delay.
        ch_mask = 4'b1111;
        idle(3, "settle23");
        for (int i = 0; i < 6; i++) cycle(1'b1, "held");
        interleave_b = 1'b0;
        for (int i = 0; i < 4; i++) cycle(1'b1, "modechg");
        interleave_b = 1'b1;
        idle(3, "settle36");
        for (int i = 0; i < 3; i++) cycle(1'b1, "to_ch3");
        check("to_ch3.const", 32'(cur_ch), 32'd3);
        rst_n = 1'b0;
        cycle(1'b1, "rst_dom");
        check("rst_dom.oe_const", 32'(output_en), 32'd0);
        rst_n = 1'b1;
        idle(3, "settle_rel");
        cycle(1'b1, "after_rst");
        check("after_rst.const", 32'(output_en), 32'b0001);

        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 7) == 0) ch_mask = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) interleave_b = ~interleave_b;
            if ($urandom_range(0, 14) == 0) ff_en = ~ff_en;
            cycle(1'($urandom_range(0, 1)), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/interleaver_n.md
INTERLEAVER_N -- requirements
Module: interleaver_n

Interface
REQ-001 Parameter NCH, default 4, number of output channels; legal range 2..8.
REQ-002 Parameter SYNC_STAGES, default 2, synchroniser depth for asynchronous control inputs; legal range 2..4.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 trigger  input  1  synchronous strobe; each cycle high is one trigger event.
REQ-006 interleave_b  input  1  asynchronous; 1 selects round-robin mode, 0 selects fixed mode.
REQ-007 ff_en  input  1  asynchronous; 1 enables outputs, 0 forces outputs off on trigger.
REQ-008 ch_mask  input  NCH  asynchronous, quasi-static; bit i=1 makes channel i eligible.
REQ-009 output_en  output  NCH  registered channel enables; one-hot or all-zero.
REQ-010 cur_ch  output  clog2(NCH)  registered index of the active channel; 0 when idle.
REQ-011 wrap  output  1  registered one-cycle pulse when the round-robin pointer wraps.

Function
REQ-012 interleave_b, ff_en and each ch_mask bit SHALL each pass through SYNC_STAGES flops before use; control latency SHALL be SYNC_STAGES cycles.
REQ-013 Trigger SHALL NOT be synchronised; a trigger sampled in cycle n SHALL update outputs at edge n+1.
REQ-014 The block SHALL have two states: IDLE (output_en all zero) and ACTIVE (exactly one output_en bit set, equal to cur_ch).
REQ-015 Trigger with ff_en_s=0 SHALL go to IDLE and set output_en=0 and cur_ch=0.
REQ-016 Trigger, ff_en_s=1, interleave_s=0 SHALL select the lowest set bit of mask_s and go to ACTIVE (fixed mode, repeatable).
REQ-017 Trigger, ff_en_s=1, interleave_s=1, state IDLE SHALL select the lowest set bit of mask_s.
REQ-018 Trigger, ff_en_s=1, interleave_s=1, state ACTIVE SHALL select the next set bit of mask_s strictly above cur_ch; if none, it SHALL wrap to the lowest set bit and assert wrap for one cycle.
REQ-019 A single-bit mask in round-robin mode SHALL reselect the same channel and assert wrap on every trigger.
REQ-020 Trigger with ff_en_s=1 and mask_s=0 SHALL go to IDLE with output_en=0 and no wrap.
REQ-021 With no trigger, output_en and cur_ch SHALL hold, and wrap SHALL be 0.
REQ-022 A mask change that clears the current channel SHALL NOT alter outputs until the next trigger, which SHALL follow REQ-018 from the held cur_ch.
REQ-023 A trigger held high SHALL advance once per cycle.
REQ-024 A mode change SHALL take effect on the first trigger after synchronisation, with no glitch on output_en.

Reset
REQ-025 When rst_n=0 at an edge, output_en=0, cur_ch=0, wrap=0, the state SHALL be IDLE, and all synchroniser flops SHALL be cleared.
REQ-026 Reset SHALL dominate a simultaneous trigger.
REQ-027 Reset mid-sequence SHALL cause the first trigger after release to behave as from IDLE.

Structure
REQ-028 NCH limits, SYNC_STAGES limits and the state encoding SHALL live in the shared package interleaver_pkg.
REQ-029 A sub-module sync_bit (SYNC_STAGES-deep, reset-clearable, shift-register inference disabled) SHALL be instantiated per asynchronous bit.
REQ-030 Next-channel selection SHALL be a combinational priority search over a mask rotated by cur_ch+1.

Verification (NCH=4, SYNC_STAGES=2)
REQ-031 Reset, then ff_en=1, interleave_b=1, mask=1111, 5 triggers -> output_en 0001,0010,0100,1000,0001, with wrap on the 5th.
REQ-032 mask=1010, interleave_b=1, 3 triggers -> 0010,1000,0010, with wrap on the 3rd.
REQ-033 interleave_b=0, mask=0110, 3 triggers -> 0010 each time, no wrap.
REQ-034 ACTIVE on ch2, then ff_en=0 for 3 cycles, then trigger -> output_en=0000, cur_ch=0.
REQ-035 ACTIVE on ch1, mask changed 1111->1001, next trigger -> 1000; following trigger -> 0001 with wrap.
REQ-036 rst_n=0 coincident with trigger while on ch3 -> 0000; first trigger after release -> 0001.
